// File: rtl/controle_multiciclo.sv
// Multicycle control FSM and PC register for the RISC-V datapath.
// Produces the PC word index and estado for fetch, plus Moore strobes
// for the register file, ALU operand select and data memory.
//
// state        | meaning
// -------------+---------------------------------------------------
// BUSCA        | fetch samples instrucoes[PC]; PC held stable
// DECODIFICA   | latch instrucao, branch on its opcode (NOP retires)
// EXEC_ALU     | R-type / I-type ALU operation
// CALC_END     | load/store address calculation (imm operand)
// ESCRITA_REG  | register file write-back, retire
// LEITURA_MEM  | data memory read
// RAMO         | beq/bne resolution on zero, retire
// SALTO        | jal: link write and jump, retire
// ESCRITA_MEM  | data memory write, retire
// FIM          | program finished, absorbing until reset
module controle_multiciclo #(
    parameter int unsigned NUM_INSTR = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrucao,
    input  logic        zero,
    output logic [31:0] PC,
    output logic [3:0]  estado,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src_imm,
    output logic        fim
);

    typedef enum logic [3:0] {
        BUSCA       = 4'b0000,
        DECODIFICA  = 4'b0001,
        EXEC_ALU    = 4'b0010,
        CALC_END    = 4'b0011,
        ESCRITA_REG = 4'b0100,
        LEITURA_MEM = 4'b0101,
        RAMO        = 4'b0110,
        SALTO       = 4'b0111,
        ESCRITA_MEM = 4'b1000,
        FIM         = 4'b1111
    } estado_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    estado_t     r_estado;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    estado_t     w_estado_next;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_target;
    logic        w_retire;
    logic [31:0] w_pc_inc;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_j;
    logic [31:0] w_off_b;
    logic [31:0] w_off_j;
    logic        w_taken;

    assign w_pc_inc = r_pc + 32'd1;

    // Immediates come from the latched instruction; byte offsets become word offsets.
    assign w_imm_b = {{20{r_instr[31]}}, r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
    assign w_imm_j = {{12{r_instr[31]}}, r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
    assign w_off_b = 32'($signed(w_imm_b) >>> 2);
    assign w_off_j = 32'($signed(w_imm_j) >>> 2);

    // beq taken on zero, bne taken on !zero, other funct3 never taken.
    always_comb begin
        w_taken = 1'b0;
        case (r_instr[14:12])
            3'b000:  w_taken = zero;
            3'b001:  w_taken = ~zero;
            default: w_taken = 1'b0;
        endcase
    end

    // Next-state and next-PC; retiring states pick BUSCA or FIM from the new PC.
    always_comb begin
        w_estado_next = BUSCA;
        w_pc_next     = r_pc;
        w_pc_target   = w_pc_inc;
        w_retire      = 1'b0;
        case (r_estado)
            BUSCA: w_estado_next = DECODIFICA;
            DECODIFICA: begin
                case (instrucao[6:0])
                    OP_R, OP_IMM:       w_estado_next = EXEC_ALU;
                    OP_LOAD, OP_STORE:  w_estado_next = CALC_END;
                    OP_BRANCH:          w_estado_next = RAMO;
                    OP_JAL:             w_estado_next = SALTO;
                    default:            w_retire      = 1'b1;
                endcase
            end
            EXEC_ALU:    w_estado_next = ESCRITA_REG;
            CALC_END:    w_estado_next = (r_instr[6:0] == OP_LOAD) ? LEITURA_MEM : ESCRITA_MEM;
            LEITURA_MEM: w_estado_next = ESCRITA_REG;
            ESCRITA_REG, ESCRITA_MEM: w_retire = 1'b1;
            RAMO: begin
                w_retire    = 1'b1;
                w_pc_target = w_taken ? (r_pc + w_off_b) : w_pc_inc;
            end
            SALTO: begin
                w_retire    = 1'b1;
                w_pc_target = r_pc + w_off_j;
            end
            FIM:     w_estado_next = FIM;
            default: w_estado_next = BUSCA;
        endcase
        // Unsigned compare also catches negative (wrapped) targets.
        if (w_retire) begin
            w_pc_next     = w_pc_target;
            w_estado_next = (w_pc_target >= 32'(NUM_INSTR)) ? FIM : BUSCA;
        end
    end

    // State, PC and instruction latch; reset dominates everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= BUSCA;
            r_pc     <= '0;
            r_instr  <= '0;
        end else begin
            r_estado <= w_estado_next;
            r_pc     <= w_pc_next;
            if (r_estado == DECODIFICA) begin
                r_instr <= instrucao;
            end
        end
    end

    // Moore strobes decoded from the current state only.
    always_comb begin
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        alu_src_imm = 1'b0;
        fim         = 1'b0;
        case (r_estado)
            ESCRITA_REG, SALTO: reg_write   = 1'b1;
            LEITURA_MEM:        mem_read    = 1'b1;
            ESCRITA_MEM:        mem_write   = 1'b1;
            EXEC_ALU:           alu_src_imm = (r_instr[6:0] == OP_IMM);
            CALC_END:           alu_src_imm = 1'b1;
            FIM:                fim         = 1'b1;
            default: ;
        endcase
    end

    assign PC     = r_pc;
    assign estado = r_estado;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: a small program in a model instruction
// memory, with per-cycle expected state/PC/strobes queued per instruction.
module tb_controle_multiciclo;

    logic        clk;
    logic        reset;
    logic [31:0] instrucao;
    logic        zero;
    logic [31:0] PC;
    logic [3:0]  estado;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src_imm;
    logic        fim;

    controle_multiciclo #(.NUM_INSTR(11)) dut (
        .clk         (clk),
        .reset       (reset),
        .instrucao   (instrucao),
        .zero        (zero),
        .PC          (PC),
        .estado      (estado),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .alu_src_imm (alu_src_imm),
        .fim         (fim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] imem [16];
    assign instrucao = imem[PC[3:0]];

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    localparam int K_ALU = 0, K_ALUI = 1, K_LOAD = 2, K_STORE = 3,
                   K_BR = 4, K_JAL = 5, K_NOP = 6;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (fields est|pc|rw|mr|mw|ais|fim)", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [3:0] st, input logic [31:0] pc,
                                       input logic rw, input logic mr, input logic mw,
                                       input logic ais, input logic f);
        return {23'b0, st, pc, rw, mr, mw, ais, f};
    endfunction

    task automatic push(input string tag, input logic [63:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic push_instr(input int kind, input int p, input int nxt);
        push($sformatf("pc%0d_dec", p), mk(4'h1, p, 0, 0, 0, 0, 0));
        case (kind)
            K_ALU: begin
                push($sformatf("pc%0d_exec", p), mk(4'h2, p, 0, 0, 0, 0, 0));
                push($sformatf("pc%0d_wreg", p), mk(4'h4, p, 1, 0, 0, 0, 0));
            end
            K_ALUI: begin
                push($sformatf("pc%0d_execi", p), mk(4'h2, p, 0, 0, 0, 1, 0));
                push($sformatf("pc%0d_wreg", p), mk(4'h4, p, 1, 0, 0, 0, 0));
            end
            K_LOAD: begin
                push($sformatf("pc%0d_calc", p), mk(4'h3, p, 0, 0, 0, 1, 0));
                push($sformatf("pc%0d_rmem", p), mk(4'h5, p, 0, 1, 0, 0, 0));
                push($sformatf("pc%0d_wreg", p), mk(4'h4, p, 1, 0, 0, 0, 0));
            end
            K_STORE: begin
                push($sformatf("pc%0d_calc", p), mk(4'h3, p, 0, 0, 0, 1, 0));
                push($sformatf("pc%0d_wmem", p), mk(4'h8, p, 0, 0, 1, 0, 0));
            end
            K_BR:  push($sformatf("pc%0d_ramo", p), mk(4'h6, p, 0, 0, 0, 0, 0));
            K_JAL: push($sformatf("pc%0d_salto", p), mk(4'h7, p, 1, 0, 0, 0, 0));
            default: ;
        endcase
        if (nxt >= 11)
            push($sformatf("pc%0d_fim", p), mk(4'hF, nxt, 0, 0, 0, 0, 1));
        else
            push($sformatf("pc%0d_next", p), mk(4'h0, nxt, 0, 0, 0, 0, 0));
    endtask

    // Pops one expectation per clock; bounded by the queue length.
    task automatic drain();
        exp_t x;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            x = sb.pop_front();
            check(x.tag, mk(estado, PC, reg_write, mem_read, mem_write, alu_src_imm, fim), x.exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) imem[i] = 32'h0000_007F;
        imem[0]  = 32'h002081B3; // add x3,x1,x2
        imem[1]  = 32'h0000A183; // lw x3,0(x1)
        imem[2]  = 32'h008000EF; // jal x1,+8
        imem[3]  = 32'h0030A023; // sw x3,0(x1)
        imem[4]  = 32'h0000007F; // unknown opcode
        imem[5]  = 32'hFE000CE3; // beq x0,x0,-8
        imem[6]  = 32'hFE001CE3; // bne x0,x0,-8
        imem[7]  = 32'h00100093; // addi x1,x0,1
        imem[8]  = 32'h00000000; // all-zero NOP
        imem[9]  = 32'h0000007F;
        imem[10] = 32'h002081B3; // add, last word

        reset = 1'b1;
        zero  = 1'b0;
        push("rst0", mk(4'h0, 0, 0, 0, 0, 0, 0));
        push("rst1", mk(4'h0, 0, 0, 0, 0, 0, 0));
        drain();
        reset = 1'b0;

        // add, then a load interrupted by reset in LEITURA_MEM
        push_instr(K_ALU, 0, 1);
        push("lw_dec",  mk(4'h1, 1, 0, 0, 0, 0, 0));
        push("lw_calc", mk(4'h3, 1, 0, 0, 0, 1, 0));
        push("lw_rmem", mk(4'h5, 1, 0, 1, 0, 0, 0));
        drain();
        reset = 1'b1;
        push("rst_mid0", mk(4'h0, 0, 0, 0, 0, 0, 0));
        push("rst_mid1", mk(4'h0, 0, 0, 0, 0, 0, 0));
        drain();
        reset = 1'b0;

        // full program
        push_instr(K_ALU,   0, 1);  drain();
        push_instr(K_LOAD,  1, 2);  drain();
        push_instr(K_JAL,   2, 4);  drain();
        push_instr(K_NOP,   4, 5);  drain();
        zero = 1'b1;
        push_instr(K_BR,    5, 3);  drain();   // beq taken
        push_instr(K_STORE, 3, 4);  drain();
        push_instr(K_NOP,   4, 5);  drain();
        zero = 1'b0;
        push_instr(K_BR,    5, 6);  drain();   // beq not taken
        push_instr(K_BR,    6, 4);  drain();   // bne taken
        push_instr(K_NOP,   4, 5);  drain();
        push_instr(K_BR,    5, 6);  drain();
        zero = 1'b1;
        push_instr(K_BR,    6, 7);  drain();   // bne not taken
        push_instr(K_ALUI,  7, 8);  drain();
        push_instr(K_NOP,   8, 9);  drain();
        push_instr(K_NOP,   9, 10); drain();
        push_instr(K_ALU,  10, 11); drain();   // runs off the end
        for (int i = 0; i < 20; i++)
            push($sformatf("fim_hold%0d", i), mk(4'hF, 11, 0, 0, 0, 0, 1));
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
